pipelined_cla_adder: RTL

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder_if.sv | 20 ++
 rtl/pipelined_cla_adder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-lookahead adder.
interface pipelined_cla_adder_if #(parameter int WIDTH = 32) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf, zero);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, ovf, zero);
endinterface

// File: rtl/pipelined_cla_adder.sv
// Add/sub split into STAGES segments; each segment is a chain of GROUP-bit lookahead
// blocks fed by the carry registered from the previous segment.
module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  pipelined_cla_adder_if.slave bus
);
  logic en;

  // Whole pipe moves as one; a held result freezes everything behind it.
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  generate
    if (STAGES < 1 || GROUP < 1 || (WIDTH % (GROUP * STAGES)) != 0) begin : g_bad
      $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP*STAGES and STAGES >= 1");
    end else begin : g_pipe
      localparam int SEG = WIDTH / STAGES;
      localparam int NG  = SEG / GROUP;
      localparam int L   = STAGES - 1;

      for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO = k * SEG;
        localparam int HI = LO + SEG;

        // ia/ib: operand bits not yet summed; s_n: sum bits known after this stage
        logic [WIDTH-1:LO] ia, ib;
        logic              ic, iv;
        logic [NG:0]       gc;
        logic [HI-1:0]     s_n;
        logic [HI-1:0]     s_r;
        logic              c_r, v_r;

        if (k == 0) begin : g_in
          assign ia = bus.a;
          assign ib = bus.sub ? ~bus.b : bus.b;
          assign ic = bus.sub | bus.cin;
          assign iv = bus.in_valid;
        end else begin : g_in
          assign ia             = stg[k-1].g_skew.a_r;
          assign ib             = stg[k-1].g_skew.b_r;
          assign ic             = stg[k-1].c_r;
          assign iv             = stg[k-1].v_r;
          assign s_n[LO-1:0]    = stg[k-1].s_r;
        end

        assign gc[0] = ic;
        for (genvar g = 0; g < NG; g++) begin : grp
          cla_group #(.W(GROUP)) u_cla (
            .a  (ia[LO+g*GROUP +: GROUP]),
            .b  (ib[LO+g*GROUP +: GROUP]),
            .ci (gc[g]),
            .s  (s_n[LO+g*GROUP +: GROUP]),
            .co (gc[g+1])
          );
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            v_r <= 1'b0;
            s_r <= '0;
            c_r <= 1'b0;
          end else if (en) begin
            v_r <= iv;
            s_r <= s_n;
            c_r <= gc[NG];
          end
        end

        if (k != L) begin : g_skew
          logic [WIDTH-1:HI] a_r, b_r;
          always_ff @(posedge clk) begin
            if (rst) begin
              a_r <= '0;
              b_r <= '0;
            end else if (en) begin
              a_r <= ia[WIDTH-1:HI];
              b_r <= ib[WIDTH-1:HI];
            end
          end
        end
      end

      logic ovf_r, zero_r;

      // Flags come from the final-stage sum so they stay aligned with it.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r  <= 1'b0;
          zero_r <= 1'b1;
        end else if (en) begin
          ovf_r  <= (stg[L].ia[WIDTH-1] == stg[L].ib[WIDTH-1]) &&
                    (stg[L].s_n[WIDTH-1] != stg[L].ia[WIDTH-1]);
          zero_r <= ~|stg[L].s_n;
        end
      end

      assign bus.out_valid = stg[L].v_r;
      assign bus.sum       = stg[L].s_r;
      assign bus.cout      = stg[L].c_r;
      assign bus.ovf       = ovf_r;
      assign bus.zero      = zero_r;
    end
  endgenerate
endmodule

module cla_group #(parameter int W = 4) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W-1:0] g, p;
  logic [W:0]   c;
  logic         acc, term;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat OR of g/p/ci product terms, never the previous carry.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    term = 1'b0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      acc = ci;
      for (int m = 0; m <= i; m++) acc = acc & p[m];
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
  end

  assign s  = p ^ c[W-1:0];
  assign co = c[W];
endmodule
